// File: rtl/uart_tx_cfg.sv
// UART transmitter with configurable data width and oversampling ratio.
// Parity (none/even/odd) and one or two stop bits are chosen per frame
// and latched when the word is accepted. Bit timing is driven by sample_tick.
module uart_tx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done_tick
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick_cnt, tick_nxt;
    logic [BIT_W-1:0]    bit_idx, bit_nxt;
    logic                stop_cnt, stop_nxt;
    logic                tx_q, tx_nxt;
    logic                done_q, done_nxt;
    logic                load;

    // Frame configuration captured at accept; not reset since it is only
    // consulted after a word has been loaded.
    logic [DATA_BITS-1:0] data_q;
    logic                 par_en_q;
    logic                 par_odd_q;
    logic                 two_stop_q;

    logic bit_end;
    logic parity_bit;

    assign bit_end    = sample_tick && (tick_cnt == TICK_LAST);
    assign parity_bit = par_odd_q ? ~(^data_q) : ^data_q;

    // Next-state, counter and registered-output decode for the frame sequencer.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_idx;
        stop_nxt  = stop_cnt;
        tx_nxt    = tx_q;
        done_nxt  = 1'b0;
        load      = 1'b0;

        // A tick coincident with accept is not counted: IDLE never advances it.
        if (state != S_IDLE && sample_tick) begin
            tick_nxt = bit_end ? '0 : tick_cnt + TICK_W'(1);
        end

        case (state)
            S_IDLE: begin
                tx_nxt = 1'b1;
                if (tx_valid) begin
                    load      = 1'b1;
                    state_nxt = S_START;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                    stop_nxt  = 1'b0;
                    tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_nxt = S_DATA;
                    bit_nxt   = '0;
                    tx_nxt    = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx == BIT_LAST) begin
                        if (par_en_q) begin
                            state_nxt = S_PARITY;
                            tx_nxt    = parity_bit;
                        end else begin
                            state_nxt = S_STOP;
                            stop_nxt  = 1'b0;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        bit_nxt = bit_idx + BIT_W'(1);
                        tx_nxt  = data_q[bit_nxt];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_nxt = S_STOP;
                    stop_nxt  = 1'b0;
                    tx_nxt    = 1'b1;
                end
            end
            S_STOP: begin
                tx_nxt = 1'b1;
                if (bit_end) begin
                    if (two_stop_q && !stop_cnt) begin
                        stop_nxt = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        stop_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

    // Control state, counters and registered line/done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_idx  <= bit_nxt;
            stop_cnt <= stop_nxt;
            tx_q     <= tx_nxt;
            done_q   <= done_nxt;
        end
    end

    // Capture the word and its frame format on accept only.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q     <= tx_data;
            par_en_q   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_odd_q  <= (parity_mode == 2'b10);
            two_stop_q <= two_stop;
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_ready     = (state == S_IDLE);
    assign tx_busy      = !tx_ready;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: default 8-bit/16x instance plus a
// 7-bit/8x instance driven with a sparse sample_tick.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset;

    logic       st_a, valid_a, ts_a;
    logic [7:0] data_a;
    logic [1:0] pm_a;
    logic       tx_a, ready_a, busy_a, done_a;

    logic       st_b, valid_b, ts_b;
    logic [6:0] data_b;
    logic [1:0] pm_b;
    logic       tx_b, ready_b, busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg dut_a (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (st_a),
        .tx_valid     (valid_a),
        .tx_data      (data_a),
        .tx_ready     (ready_a),
        .parity_mode  (pm_a),
        .two_stop     (ts_a),
        .tx           (tx_a),
        .tx_busy      (busy_a),
        .tx_done_tick (done_a)
    );

    uart_tx_cfg #(.DATA_BITS(7), .OVERSAMPLE(8)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (st_b),
        .tx_valid     (valid_b),
        .tx_data      (data_b),
        .tx_ready     (ready_b),
        .parity_mode  (pm_b),
        .two_stop     (ts_b),
        .tx           (tx_b),
        .tx_busy      (busy_b),
        .tx_done_tick (done_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word on instance A for a single accept edge, then scramble
    // the inputs so any late sampling shows up in the frame.
    task automatic accept_a(input logic [7:0] d, input logic [1:0] pm, input logic ts);
        valid_a = 1'b1;
        data_a  = d;
        pm_a    = pm;
        ts_a    = ts;
        step();
        valid_a = 1'b0;
        data_a  = ~d;
        pm_a    = ~pm;
        ts_a    = ~ts;
    endtask

    // Called right after the accept edge; checks each bit is held 16 cycles,
    // busy stays high, and done pulses only after the last stop bit.
    task automatic frame_a(input string tag, input logic [11:0] exp, input int nbits);
        int good;
        int dones;
        int busy_cnt;
        dones    = 0;
        busy_cnt = 0;
        for (int j = 0; j < nbits; j++) begin
            good = 0;
            for (int s = 0; s < 16; s++) begin
                if (tx_a === exp[j]) good++;
                if (done_a) dones++;
                if (busy_a) busy_cnt++;
                step();
            end
            check($sformatf("%s_bit%0d", tag, j), good, 16);
        end
        check($sformatf("%s_early_done", tag), dones, 0);
        check($sformatf("%s_busy", tag), busy_cnt, nbits * 16);
        check($sformatf("%s_done", tag), int'(done_a), 1);
        check($sformatf("%s_tx_idle", tag), int'(tx_a), 1);
    endtask

    initial begin
        int dones;
        int good;
        int highs;
        logic [11:0] exp_b;

        reset   = 1'b1;
        st_a    = 1'b1;
        valid_a = 1'b0;
        data_a  = 8'h00;
        pm_a    = 2'b00;
        ts_a    = 1'b0;
        st_b    = 1'b0;
        valid_b = 1'b0;
        data_b  = 7'h00;
        pm_b    = 2'b00;
        ts_b    = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_tx", int'(tx_a), 1);
        check("rst_ready", int'(ready_a), 1);
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_b_tx", int'(tx_b), 1);
        check("rst_b_ready", int'(ready_b), 1);

        // 8N1 0xA5
        accept_a(8'hA5, 2'b00, 1'b0);
        frame_a("a5", 12'b00_1101001010, 10);
        step();
        check("a5_ready_after", int'(ready_a), 1);
        check("a5_done_cleared", int'(done_a), 0);

        // Even and odd parity on 0x07
        accept_a(8'h07, 2'b01, 1'b0);
        frame_a("even07", 12'b0_11000001110, 11);
        step();
        accept_a(8'h07, 2'b10, 1'b0);
        frame_a("odd07", 12'b0_10000001110, 11);
        step();

        // Two stop bits on 0x00; two_stop is flipped right after accept
        accept_a(8'h00, 2'b00, 1'b1);
        frame_a("stop2", 12'b0_11000000000, 11);
        step();

        // Held valid: second word waits for ready, frames follow immediately
        valid_a = 1'b1;
        data_a  = 8'h55;
        pm_a    = 2'b00;
        ts_a    = 1'b0;
        step();
        data_a = 8'hAA;
        frame_a("b2b_55", 12'b00_1010101010, 10);
        check("b2b_ready_at_done", int'(ready_a), 1);
        step();
        valid_a = 1'b0;
        data_a  = 8'h00;
        frame_a("b2b_aa", 12'b00_1101010100, 10);
        step();
        check("b2b_idle", int'(busy_a), 0);

        // Reset 70 ticks into a frame
        accept_a(8'hFF, 2'b00, 1'b0);
        repeat (70) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_tx", int'(tx_a), 1);
        check("mid_rst_ready", int'(ready_a), 1);
        check("mid_rst_busy", int'(busy_a), 0);
        check("mid_rst_done", int'(done_a), 0);
        dones = 0;
        highs = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (done_a) dones++;
            if (tx_a) highs++;
        end
        check("mid_rst_no_done", dones, 0);
        check("mid_rst_line_idle", highs, 200);
        accept_a(8'h3C, 2'b00, 1'b0);
        frame_a("after_rst_3c", 12'b00_1001111000, 10);
        step();

        // 7 data bits, 8x oversample, tick every 3rd cycle, even parity
        exp_b   = 12'b00_1010000010;
        valid_b = 1'b1;
        data_b  = 7'h41;
        pm_b    = 2'b01;
        ts_b    = 1'b0;
        st_b    = 1'b0;
        step();
        valid_b = 1'b0;
        data_b  = 7'h00;
        pm_b    = 2'b00;
        dones   = 0;
        for (int j = 0; j < 10; j++) begin
            good = 0;
            for (int s = 0; s < 24; s++) begin
                if (tx_b === exp_b[j]) good++;
                if (done_b) dones++;
                st_b = (((j * 24 + s + 1) % 3) == 0);
                step();
            end
            check($sformatf("b41_bit%0d", j), good, 24);
        end
        st_b = 1'b0;
        check("b41_early_done", dones, 0);
        check("b41_done", int'(done_b), 1);
        check("b41_tx_idle", int'(tx_b), 1);
        step();
        check("b41_ready_after", int'(ready_b), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
